hilo_muldiv: RTL and testbench

Iterative multiply/divide unit owning the architectural HI/LO registers of the multi-cycle MIPS core. It executes MULT, MULTU, DIV, DIVU over 34 busy cycles, takes MTHI/MTLO in one cycle, and presents HI/LO continuously for MFHI/MFLO. It sits beside the ALU, consuming the same rs/rt register outputs, and returns 64-bit results to the register file path through Hi/Lo. This removes single-cycle `*`, `/` and `%` from the ALU critical path.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/hilo_muldiv_if.sv | 23 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/hilo_muldiv.sv | 142 ++++++++++++++
 tb/tb_hilo_muldiv.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core types: mul/div opcodes, HI/LO unit states
// and a conditional two's-complement helper.
package mips_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    FIX
  } md_state_t;

  function automatic logic [31:0] neg_if(
    input logic [31:0] v,
    input logic        neg
  );
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the control unit and the
// HI/LO multiply/divide unit.
interface hilo_muldiv_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  modport master (
    output Start, Op, OperandA, OperandB,
    input  Busy, Done, DivByZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, OperandA, OperandB,
    output Busy, Done, DivByZero, Hi, Lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide
// on a packed {upper, lower} 64-bit accumulator.
module muldiv_step (
  input  logic [63:0] i_acc,
  input  logic [31:0] i_opnd,
  input  logic        i_is_div,
  output logic [63:0] o_acc,
  output logic        o_qbit
);

  logic [32:0] w_sum;
  logic [32:0] w_shl;
  logic        w_ge;
  logic [31:0] w_diff;

  // The true difference is below the divisor, so 32 bits hold it.
  always_comb begin
    w_sum  = {1'b0, i_acc[63:32]} + {1'b0, i_opnd};
    w_shl  = {i_acc[63:32], i_acc[31]};
    w_ge   = w_shl >= {1'b0, i_opnd};
    w_diff = w_shl[31:0] - i_opnd;
    o_qbit = 1'b0;
    o_acc  = i_acc;
    if (i_is_div) begin
      o_qbit = w_ge;
      o_acc  = {(w_ge ? w_diff : w_shl[31:0]),
                i_acc[30:0], 1'b0};
    end else if (i_acc[0]) begin
      o_acc = {w_sum, i_acc[31:1]};
    end else begin
      o_acc = {1'b0, i_acc[63:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO
// registers; 34 busy cycles per op, MTHI/MTLO in one.
module hilo_muldiv
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  hilo_muldiv_if.slave  bus
);

  md_state_t   r_state;
  md_state_t   w_next;
  md_op_t      r_op;
  logic        r_sign_a;
  logic        r_sign_b;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_mag_b;
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic        r_dbz;

  md_op_t      w_op;
  logic        w_start;
  logic        w_op_md;
  logic        w_op_sgn;
  logic        w_div_r;
  logic [63:0] w_step_acc;
  logic        w_qbit;
  logic [63:0] w_prod;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  assign w_op     = md_op_t'(bus.Op);
  assign w_start  = bus.Start && (r_state == IDLE);
  assign w_op_md  = ~bus.Op[2];
  assign w_op_sgn = (w_op == MD_MULT) || (w_op == MD_DIV);
  assign w_div_r  = (r_op == MD_DIV) || (r_op == MD_DIVU);

  muldiv_step u_step (
    .i_acc    (r_acc),
    .i_opnd   (r_mag_b),
    .i_is_div (w_div_r),
    .o_acc    (w_step_acc),
    .o_qbit   (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start && w_op_md) w_next = PREP;
      PREP:    w_next = RUN;
      RUN:     if (r_cnt == 5'd31) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Sign latches are zero for unsigned ops, so no op test here.
  always_comb begin
    w_prod = r_acc;
    if (r_sign_a ^ r_sign_b) w_prod = ~r_acc + 64'd1;
    w_fix_hi = w_prod[63:32];
    w_fix_lo = w_prod[31:0];
    if (w_div_r) begin
      if (r_b == 32'd0) begin
        w_fix_hi = r_a;
        w_fix_lo = 32'hFFFF_FFFF;
      end else begin
        w_fix_hi = neg_if(r_acc[63:32], r_sign_a);
        w_fix_lo = neg_if(r_acc[31:0], r_sign_a ^ r_sign_b);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_op     <= MD_MULT;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= (r_state == FIX);
      r_dbz  <= (r_state == FIX) && w_div_r
                && (r_b == 32'd0);
      unique case (r_state)
        IDLE: if (w_start) begin
          unique case (1'b1)
            w_op_md: begin
              r_op     <= w_op;
              r_a      <= bus.OperandA;
              r_b      <= bus.OperandB;
              r_sign_a <= w_op_sgn & bus.OperandA[31];
              r_sign_b <= w_op_sgn & bus.OperandB[31];
            end
            (w_op == MD_MTHI): r_hi <= bus.OperandA;
            (w_op == MD_MTLO): r_lo <= bus.OperandA;
            default: ;
          endcase
        end
        PREP: begin
          r_acc   <= {32'd0, neg_if(r_a, r_sign_a)};
          r_mag_b <= neg_if(r_b, r_sign_b);
          r_cnt   <= '0;
        end
        RUN: begin
          r_acc <= {w_step_acc[63:1],
                    w_step_acc[0] | w_qbit};
          r_cnt <= r_cnt + 5'd1;
        end
        FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy      = (r_state != IDLE);
  assign bus.Done      = r_done;
  assign bus.DivByZero = r_dbz;
  assign bus.Hi        = r_hi;
  assign bus.Lo        = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed plus random checks of hilo_muldiv against an
// arithmetic reference model.
module tb_hilo_muldiv;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  hilo_muldiv_if bus();

  hilo_muldiv dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic void model(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dbz
  );
    longint sp, sa, sb, q, r;
    logic [63:0] up;
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    case (op)
      MD_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = sp[63:0];
      end
      MD_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {hi, lo} = up;
      end
      MD_DIV, MD_DIVU: begin
        if (b == 32'd0) begin
          hi  = a;
          lo  = 32'hFFFF_FFFF;
          dbz = 1'b1;
        end else if (op == MD_DIV) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Entered just after a falling edge; returns in the Done cycle.
  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] eh, el;
    logic ed;
    int cyc;
    model(op, a, b, eh, el, ed);
    bus.Start = 1'b1;
    bus.Op = op;
    bus.OperandA = a;
    bus.OperandB = b;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    cyc = 0;
    @(negedge clk);
    chk("done_low_busy", {63'd0, bus.Done}, 64'd0);
    while (bus.Busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(cyc), 64'd34);
    chk("done", {63'd0, bus.Done}, 64'd1);
    chk("hi", {32'd0, bus.Hi}, {32'd0, eh});
    chk("lo", {32'd0, bus.Lo}, {32'd0, el});
    chk("dbz", {63'd0, bus.DivByZero}, {63'd0, ed});
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic run_mt(input logic [2:0] op,
                        input logic [31:0] a);
    bus.Start = 1'b1;
    bus.Op = op;
    bus.OperandA = a;
    bus.OperandB = $urandom;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    if (op == MD_MTHI) m_hi = a;
    if (op == MD_MTLO) m_lo = a;
    @(negedge clk);
    chk("mt_busy", {63'd0, bus.Busy}, 64'd0);
    chk("mt_done", {63'd0, bus.Done}, 64'd0);
    chk("mt_hi", {32'd0, bus.Hi}, {32'd0, m_hi});
    chk("mt_lo", {32'd0, bus.Lo}, {32'd0, m_lo});
  endtask

  initial begin
    logic [31:0] eh, el, a, b;
    logic ed;
    logic [2:0] op;
    int cyc, seen;

    bus.Start = 1'b0;
    bus.Op = '0;
    bus.OperandA = '0;
    bus.OperandB = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, bus.Busy}, 64'd0);
    chk("rst_done", {63'd0, bus.Done}, 64'd0);
    chk("rst_dbz", {63'd0, bus.DivByZero}, 64'd0);
    chk("rst_hi", {32'd0, bus.Hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.Lo}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    @(negedge clk);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    run_op(MD_DIVU, 32'd7, 32'd2);
    // Back-to-back: start issued in the Done cycle.
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(MD_DIVU, 32'h1234_5678, 32'd0);
    @(negedge clk);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0);
    @(negedge clk);
    run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000);
    run_mt(MD_MTLO, 32'hCAFE_BABE);
    run_mt(MD_MTHI, 32'h0BAD_F00D);

    // Mid-run MTHI and MULT requests must be dropped.
    model(MD_MULT, 32'd5, 32'hFFFF_FFFA, eh, el, ed);
    bus.Start = 1'b1;
    bus.Op = MD_MULT;
    bus.OperandA = 32'd5;
    bus.OperandB = 32'hFFFF_FFFA;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    cyc = 0;
    repeat (10) begin
      @(negedge clk);
      cyc++;
    end
    bus.Start = 1'b1;
    bus.Op = MD_MTHI;
    bus.OperandA = 32'hDEAD_BEEF;
    @(negedge clk);
    cyc++;
    bus.Op = MD_MULT;
    bus.OperandA = 32'd9;
    bus.OperandB = 32'd9;
    @(negedge clk);
    cyc++;
    bus.Start = 1'b0;
    @(negedge clk);
    while (bus.Busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("ign_cycles", 64'(cyc), 64'd34);
    chk("ign_done", {63'd0, bus.Done}, 64'd1);
    chk("ign_hi", {32'd0, bus.Hi}, {32'd0, eh});
    chk("ign_lo", {32'd0, bus.Lo}, {32'd0, el});
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    chk("ign_no_restart", {63'd0, bus.Busy}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) b = b >> 20;
      if (op <= 3'd3) run_op(op, a, b);
      else run_mt(op, a);
    end

    // Reset while RUN is at count 10 aborts the op.
    @(negedge clk);
    run_mt(MD_MTHI, 32'h1234_0000);
    run_mt(MD_MTLO, 32'h0000_5678);
    bus.Start = 1'b1;
    bus.Op = MD_MULTU;
    bus.OperandA = 32'hFFFF_FFFF;
    bus.OperandB = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    chk("abort_busy", {63'd0, bus.Busy}, 64'd0);
    chk("abort_hi", {32'd0, bus.Hi}, {32'd0, m_hi});
    chk("abort_lo", {32'd0, bus.Lo}, {32'd0, m_lo});
    seen = 0;
    repeat (40) begin
      if (bus.Done === 1'b1) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_hi_hold", {32'd0, bus.Hi}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
